// File: rtl/aes_inv_pkg.sv
// rtl/aes_inv_pkg.sv - AES-128 inverse cipher types, inverse S-box and round helper functions
package aes_inv_pkg;

  localparam int AES128_NR = 10;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Byte k sits at [127-8k -: 8]; row = k%4, col = k/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[127 - 8*k -: 8] = INV_SBOX[s[127 - 8*k -: 8]];
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - combinational AES inverse round; last_round skips InvMixColumns
module aes_inv_round
  import aes_inv_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         last_round,
  output logic [127:0] next_state
);

  logic [127:0] keyed;
  logic [127:0] mixed;

  always_comb begin
    keyed = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
    mixed = '0;
    for (int c = 0; c < 4; c++)
      mixed[127 - 32*c -: 32] = inv_mix_column(keyed[127 - 32*c -: 32]);
    next_state = last_round ? keyed : mixed;
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128 decrypt core, one inverse round per clock
// Optional abort port enabled by defining AES_INV_ABORT_EN.
module aes_inv_cipher_iter
  import aes_inv_pkg::*;
#(
  parameter int NR            = AES128_NR,
  parameter bit ZERO_OUT_IDLE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt_out,
  output logic         busy
`ifdef AES_INV_ABORT_EN
  ,
  input  logic         abort
`endif
);

  if (NR != AES128_NR) begin : g_nr_check
    $error("aes_inv_cipher_iter only supports NR = 10");
  end

  localparam logic [3:0] CTR_START = 4'(NR - 1);
  localparam logic [3:0] LAST_KEY  = 4'(NR);

  state_t       fsm_q, fsm_d;
  logic [3:0]   ctr_q, ctr_d;
  logic [127:0] st_q, st_d;
  logic [127:0] round_out;
  logic         last_round;
  logic         abort_req;

`ifdef AES_INV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  aes_inv_round u_round (
    .state      (st_q),
    .rk         (rk_in),
    .last_round (last_round),
    .next_state (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      ctr_q <= CTR_START;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      ctr_q <= ctr_d;
      st_q  <= st_d;
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    ctr_d      = ctr_q;
    st_d       = st_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    rk_idx     = LAST_KEY;
    last_round = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          st_d  = ct_in ^ rk_in;
          ctr_d = CTR_START;
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        rk_idx = ctr_q;
        st_d   = round_out;
        if (ctr_q == 4'd1) fsm_d = FINAL;
        else               ctr_d = ctr_q - 4'd1;
      end
      FINAL: begin
        rk_idx     = 4'd0;
        last_round = 1'b1;
        st_d       = round_out;
        fsm_d      = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    // Abort discards the block and wins over a same-cycle output handshake.
    if (abort_req && fsm_q != IDLE) begin
      fsm_d = IDLE;
      st_d  = '0;
      ctr_d = CTR_START;
    end
  end

  assign pt_out = (ZERO_OUT_IDLE && !out_valid) ? '0 : st_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb/tb_aes_inv_cipher_iter.sv - self-checking bench: FIPS vectors, forward-cipher model, handshake corners
// Abort checks are included when AES_INV_ABORT_EN is defined.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt_out;
  logic         busy;
`ifdef AES_INV_ABORT_EN
  logic         abort;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [127:0] rks [0:10];
  logic [7:0]   sbox_t [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rk_in = (rk_idx <= 4'd10) ? rks[rk_idx] : '0;

  aes_inv_cipher_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_in     (ct_in),
    .rk_idx    (rk_idx),
    .rk_in     (rk_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt_out    (pt_out),
`ifdef AES_INV_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: forward AES-128 built from field arithmetic.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h01;
    for (int i = 0; i < 254; i++) b = m_mul(b, x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt_m(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    v = pt ^ rks[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox_t[v[127 - 8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = m_mul(8'h02, t[4*c]) ^ m_mul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ m_mul(8'h02, t[4*c+1]) ^ m_mul(8'h03, t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ m_mul(8'h02, t[4*c+2]) ^ m_mul(8'h03, t[4*c+3]);
          s[4*c+3] = m_mul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ m_mul(8'h02, t[4*c+3]);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int k = 0; k < 16; k++) v[127 - 8*k -: 8] = s[k];
      v = v ^ rks[rnd];
    end
    return v;
  endfunction

  // Entered just after a rising edge; leaves just after a rising edge with the core idle.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp_pt,
                           input int hold, input bit poke, input string tag);
    int k, lat;
    in_valid = 1'b1;
    ct_in    = ct;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " accept"}, 128'(in_ready), 128'(1));
    chk({tag, " rk_idx c0"}, 128'(rk_idx), 128'(10));
    @(posedge clk); #1;
    in_valid = 1'b0;
    ct_in    = {$urandom, $urandom, $urandom, $urandom};
    lat = -1;
    for (int i = 1; i <= 30 && lat < 0; i++) begin
      @(negedge clk);
      if (i <= 10) chk($sformatf("%s rk_idx c%0d", tag, i), 128'(rk_idx), 128'(10 - i));
      if (out_valid) lat = i;
      if (poke && i == 3) begin
        in_valid = 1'b1;
        ct_in    = ~ct;
      end
      if (poke && i == 4) begin
        chk({tag, " in_ready while busy"}, 128'(in_ready), 128'(0));
        in_valid = 1'b0;
      end
    end
    chk({tag, " latency"}, 128'(lat), 128'(11));
    if (lat < 0) return;
    chk({tag, " pt_out"}, pt_out, exp_pt);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("%s hold%0d out_valid", tag, h), 128'(out_valid), 128'(1));
      chk($sformatf("%s hold%0d pt_out", tag, h), pt_out, exp_pt);
      chk($sformatf("%s hold%0d in_ready", tag, h), 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " out_valid after handshake"}, 128'(out_valid), 128'(0));
    chk({tag, " in_ready after handshake"}, 128'(in_ready), 128'(1));
    chk({tag, " busy after handshake"}, 128'(busy), 128'(0));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           hold;
    bit           poke;
  } vec_t;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    vec_t         vecs [3];
    logic [127:0] key, pt, ct, pt2, ct2;
    logic [127:0] out_d [2];
    int           acc_c [2];
    int           out_c [2];
    int           acc_n, out_n, seen;

    vecs[0] = '{C1_KEY, C1_CT, C1_PT, 0, 1'b0};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734, 0, 1'b1};
    vecs[2] = '{C1_KEY, C1_CT, C1_PT, 6, 1'b0};

    for (int x = 0; x < 256; x++) sbox_t[x] = m_sbox(8'(x));

    rst       = 1'b1;
    in_valid  = 1'b0;
    ct_in     = '0;
    out_ready = 1'b0;
`ifdef AES_INV_ABORT_EN
    abort     = 1'b0;
`endif
    expand_key(C1_KEY);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 128'(in_ready), 128'(1));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset pt_out", pt_out, '0);
    chk("reset rk_idx", 128'(rk_idx), 128'(10));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
      expand_key(vecs[v].key);
      run_block(vecs[v].ct, vecs[v].pt, vecs[v].hold, vecs[v].poke, $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 6; r++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key);
      ct = encrypt_m(pt);
      run_block(ct, pt, int'($urandom_range(2)), 1'b0, $sformatf("rand%0d", r));
    end

    // Back-to-back: in_valid held high throughout, consumer always ready.
    expand_key(C1_KEY);
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    ct2 = encrypt_m(pt2);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ct_in     = C1_CT;
    acc_n = 0;
    out_n = 0;
    for (int i = 0; i < 60 && out_n < 2; i++) begin
      @(negedge clk);
      if (in_valid && in_ready && acc_n < 2) begin
        acc_c[acc_n] = cyc;
        acc_n++;
      end
      if (out_valid && out_n < 2) begin
        out_c[out_n] = cyc;
        out_d[out_n] = pt_out;
        out_n++;
      end
      @(posedge clk); #1;
      if (acc_n >= 1) ct_in = ct2;
      if (acc_n >= 2) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b accepts", 128'(acc_n), 128'(2));
    chk("b2b outputs", 128'(out_n), 128'(2));
    if (acc_n == 2 && out_n == 2) begin
      chk("b2b spacing", 128'(acc_c[1] - acc_c[0]), 128'(12));
      chk("b2b latency", 128'(out_c[0] - acc_c[0]), 128'(11));
      chk("b2b pt0", out_d[0], C1_PT);
      chk("b2b pt1", out_d[1], pt2);
    end
    @(posedge clk); #1;

    // Reset in the 5th ROUND cycle.
    in_valid = 1'b1;
    ct_in    = C1_CT;
    @(negedge clk);
    chk("rst-mid accept", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst-mid round5 rk_idx", 128'(rk_idx), 128'(5));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst-mid in_ready", 128'(in_ready), 128'(1));
    chk("rst-mid out_valid", 128'(out_valid), 128'(0));
    chk("rst-mid pt_out", pt_out, '0);
    chk("rst-mid rk_idx", 128'(rk_idx), 128'(10));
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst-mid no output", 128'(seen), 128'(0));
    @(posedge clk); #1;
    run_block(C1_CT, C1_PT, 0, 1'b0, "post-rst");

`ifdef AES_INV_ABORT_EN
    // Abort in FINAL.
    in_valid = 1'b1;
    ct_in    = C1_CT;
    @(negedge clk);
    chk("abort-final accept", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abort-final in FINAL", 128'(rk_idx), 128'(0));
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort-final out_valid", 128'(out_valid), 128'(0));
    chk("abort-final in_ready", 128'(in_ready), 128'(1));
    chk("abort-final state", dut.st_q, '0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort-final no output", 128'(seen), 128'(0));
    @(posedge clk); #1;

    // Abort together with out_ready in DONE.
    in_valid = 1'b1;
    ct_in    = C1_CT;
    @(negedge clk);
    chk("abort-done accept", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
    chk("abort-done reached DONE", 128'(out_valid), 128'(1));
    chk("abort-done pt before abort", pt_out, C1_PT);
    @(posedge clk); #1;
    out_ready = 1'b1;
    abort     = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    chk("abort-done out_valid", 128'(out_valid), 128'(0));
    chk("abort-done in_ready", 128'(in_ready), 128'(1));
    chk("abort-done state", dut.st_q, '0);
    @(posedge clk); #1;
    run_block(C1_CT, C1_PT, 0, 1'b0, "post-abort");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
